// File: rtl/iob_bfifo_field_reader.sv
// Field reader for the iob_bfifo bit FIFO: pops one right-aligned field per width command.
// Optional macro IOB_BFIFO_FIELD_SEXT_EN adds cmd_signed_i and sign-extends fields.
module iob_bfifo_field_reader #(
  parameter int DATA_W = 21,
  localparam int CW = $clog2(DATA_W) + 1,
  localparam int LW = $clog2(2 * DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CW-1:0]     cmd_width_i,
`ifdef IOB_BFIFO_FIELD_SEXT_EN
  input  logic              cmd_signed_i,
`endif
  input  logic [LW-1:0]     bf_rlevel_i,
  input  logic [DATA_W-1:0] bf_rdata_i,
  output logic              bf_read_o,
  output logic [CW-1:0]     bf_rwidth_o,
  output logic              field_valid_o,
  input  logic              field_ready_i,
  output logic [DATA_W-1:0] field_o,
  output logic [CW-1:0]     field_width_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [CW-1:0] DW_C = CW'(DATA_W);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_width;
  logic [DATA_W-1:0] r_field;
  logic [CW-1:0]     r_field_width;
  logic              r_valid;

  logic              w_accept;
  logic [CW-1:0]     w_width_clamped;
  logic              w_level_ok;
  logic              w_read;
  logic [CW-1:0]     w_shift;
  logic [DATA_W-1:0] w_field;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  assign cmd_ready_o = (r_state == S_IDLE) || ((r_state == S_OUT) && field_ready_i);
  assign w_accept    = cmd_valid_i && cmd_ready_o;

  assign w_width_clamped = (cmd_width_i > DW_C) ? DW_C : cmd_width_i;
  assign w_level_ok      = bf_rlevel_i >= LW'(r_width);

  // The read strobe is suppressed during reset so a discarded command never pops bits.
  assign w_read      = (r_state == S_WAIT) && w_level_ok && !rst_i;
  assign bf_read_o   = w_read;
  assign bf_rwidth_o = w_read ? r_width : '0;

  assign w_shift = DW_C - r_width;

`ifdef IOB_BFIFO_FIELD_SEXT_EN
  logic              r_signed;
  logic [DATA_W-1:0] w_field_s;
  // Arithmetic shift replicates the field MSB (rdata MSB) into the upper bits.
  assign w_field_s = DATA_W'($signed(bf_rdata_i) >>> w_shift);
  assign w_field   = r_signed ? w_field_s : (bf_rdata_i >> w_shift);
`else
  assign w_field = bf_rdata_i >> w_shift;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_width       <= '0;
      r_field       <= '0;
      r_field_width <= '0;
      r_valid       <= 1'b0;
`ifdef IOB_BFIFO_FIELD_SEXT_EN
      r_signed      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_read) begin
            r_field       <= w_field;
            r_field_width <= r_width;
            r_valid       <= 1'b1;
            r_state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (field_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: ;
        default: r_state <= S_IDLE;
      endcase

      // A command accept (from IDLE or on the OUT handshake) overrides the case above.
      if (w_accept) begin
        r_width <= w_width_clamped;
`ifdef IOB_BFIFO_FIELD_SEXT_EN
        r_signed <= cmd_signed_i;
`endif
        if (w_width_clamped == '0) begin
          r_field       <= '0;
          r_field_width <= '0;
          r_valid       <= 1'b1;
          r_state       <= S_OUT;
        end else begin
          r_valid <= 1'b0;
          r_state <= S_WAIT;
        end
      end
    end
  end

  assign field_valid_o = r_valid;
  assign field_o       = r_field;
  assign field_width_o = r_field_width;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_iob_bfifo_field_reader.sv
// Bench for iob_bfifo_field_reader (DATA_W=21): directed table, corner sequences, random vs model.
module tb_iob_bfifo_field_reader;
  localparam int DW = 21;
  localparam int CW = $clog2(DW) + 1;
  localparam int LW = $clog2(2 * DW) + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [CW-1:0] cmd_width_i;
  logic          cmd_signed_i;
  logic [LW-1:0] bf_rlevel_i;
  logic [DW-1:0] bf_rdata_i;
  logic          bf_read_o;
  logic [CW-1:0] bf_rwidth_o;
  logic          field_valid_o;
  logic          field_ready_i;
  logic [DW-1:0] field_o;
  logic [CW-1:0] field_width_o;
  logic [1:0]    dbg_state_o;

  int n_vec = 0;
  int n_err = 0;

  // Expected fields, pushed when the model predicts a capture and popped on handshake.
  logic [DW-1:0] exp_q[$];

  iob_bfifo_field_reader #(.DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_width_i(cmd_width_i),
`ifdef IOB_BFIFO_FIELD_SEXT_EN
    .cmd_signed_i(cmd_signed_i),
`endif
    .bf_rlevel_i(bf_rlevel_i), .bf_rdata_i(bf_rdata_i),
    .bf_read_o(bf_read_o), .bf_rwidth_o(bf_rwidth_o),
    .field_valid_o(field_valid_o), .field_ready_i(field_ready_i),
    .field_o(field_o), .field_width_o(field_width_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_width_i = '0; cmd_signed_i = 1'b0;
    bf_rlevel_i = '0; bf_rdata_i = '0; field_ready_i = 1'b1;
  endtask

  // Reference: the field is the top w bits of rdata, right-aligned, optionally sign-extended.
  function automatic logic [DW-1:0] ref_field(input logic [DW-1:0] rd, input int w, input bit sg);
    longint v;
    if (w == 0) return '0;
    v = longint'(rd) / (longint'(1) << (DW - w));
`ifdef IOB_BFIFO_FIELD_SEXT_EN
    if (sg && ((v >> (w - 1)) & 1) == 1) v = v - (longint'(1) << w);
`else
    if (sg) v = v;
`endif
    return DW'(v);
  endfunction

  function automatic int clamp_w(input int w);
    return (w > DW) ? DW : w;
  endfunction

  typedef struct {
    int            level;
    logic [DW-1:0] rdata;
    int            width;
    bit            sgn;
    logic [DW-1:0] exp_field;
    int            exp_width;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    tick();
    cmd_valid_i = 1'b1; cmd_width_i = CW'(v.width); cmd_signed_i = v.sgn;
    bf_rlevel_i = LW'(v.level); bf_rdata_i = v.rdata; field_ready_i = 1'b1;
    @(negedge clk);
    chk("tbl_cmd_ready", 32'(cmd_ready_o), 1);
    tick();
    cmd_valid_i = 1'b0;
    @(negedge clk);
    if (v.exp_width != 0) begin
      chk("tbl_read", 32'(bf_read_o), 1);
      chk("tbl_rwidth", 32'(bf_rwidth_o), 32'(v.exp_width));
      chk("tbl_valid_early", 32'(field_valid_o), 0);
      tick();
      @(negedge clk);
    end
    chk("tbl_read_off", 32'(bf_read_o), 0);
    chk("tbl_valid", 32'(field_valid_o), 1);
    chk("tbl_field", 32'(field_o), 32'(v.exp_field));
    chk("tbl_fwidth", 32'(field_width_o), 32'(v.exp_width));
    tick();
    @(negedge clk);
    chk("tbl_valid_clr", 32'(field_valid_o), 0);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(field_valid_o), 0);
    chk("rst_field", 32'(field_o), 0);
    chk("rst_fwidth", 32'(field_width_o), 0);
    chk("rst_read", 32'(bf_read_o), 0);
    chk("rst_rwidth", 32'(bf_rwidth_o), 0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 1);

    vecs.push_back('{21, 21'h1A5000, 8, 1'b0, 21'h0000D2, 8});
    vecs.push_back('{0, 21'h1FFFFF, 0, 1'b0, 21'h000000, 0});
    vecs.push_back('{42, 21'h012345, 25, 1'b0, 21'h012345, 21});
    vecs.push_back('{3, 21'h100000, 1, 1'b0, 21'h000001, 1});
    vecs.push_back('{20, 21'h0ABCDE, 20, 1'b0, 21'h055E6F, 20});
    vecs.push_back('{21, 21'h1FFFFF, 0, 1'b1, 21'h000000, 0});
`ifdef IOB_BFIFO_FIELD_SEXT_EN
    vecs.push_back('{21, 21'h140000, 4, 1'b1, 21'h1FFFFA, 4});
    vecs.push_back('{21, 21'h0A0000, 4, 1'b1, 21'h000005, 4});
`else
    vecs.push_back('{21, 21'h140000, 4, 1'b1, 21'h00000A, 4});
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    // Insufficient level: no read until the level reaches the width.
    tick();
    cmd_valid_i = 1'b1; cmd_width_i = 6'd8; bf_rlevel_i = 7'd5; bf_rdata_i = 21'h0F0000;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lvl_no_read", 32'(bf_read_o), 0);
      chk("lvl_rwidth0", 32'(bf_rwidth_o), 0);
      tick();
    end
    bf_rlevel_i = 7'd8;
    @(negedge clk);
    chk("lvl_read", 32'(bf_read_o), 1);
    tick();
    @(negedge clk);
    chk("lvl_valid", 32'(field_valid_o), 1);
    chk("lvl_field", 32'(field_o), 32'h000078);

    // Consumer stall: field held, no command accepted, no reads.
    field_ready_i = 1'b0; cmd_valid_i = 1'b1; cmd_width_i = 6'd3; bf_rlevel_i = 7'd42;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_field", 32'(field_o), 32'h000078);
      chk("stall_valid", 32'(field_valid_o), 1);
      chk("stall_cmd_ready", 32'(cmd_ready_o), 0);
      chk("stall_read", 32'(bf_read_o), 0);
      tick();
    end
    // Back-to-back with ready high: one field every two cycles.
    field_ready_i = 1'b1; bf_rdata_i = 21'h1C0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_cmd_ready", 32'(cmd_ready_o), (i % 2 == 0) ? 1 : 0);
      chk("b2b_read", 32'(bf_read_o), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0 && i > 0) chk("b2b_field", 32'(field_o), 32'h000007);
      tick();
    end
    cmd_valid_i = 1'b0;
    repeat (3) tick();

    // Reset while waiting: no read in the reset cycle, everything cleared after.
    cmd_valid_i = 1'b1; cmd_width_i = 6'd8; bf_rlevel_i = 7'd0;
    tick();
    cmd_valid_i = 1'b0; bf_rlevel_i = 7'd21; rst_i = 1'b1;
    @(negedge clk);
    chk("rstw_no_read", 32'(bf_read_o), 0);
    tick();
    rst_i = 1'b0; bf_rlevel_i = 7'd0;
    @(negedge clk);
    chk("rstw_valid", 32'(field_valid_o), 0);
    chk("rstw_field", 32'(field_o), 0);
    chk("rstw_read", 32'(bf_read_o), 0);
    chk("rstw_cmd_ready", 32'(cmd_ready_o), 1);
    bf_rlevel_i = 7'd21;
    @(negedge clk);
    chk("rstw_stays_idle", 32'(bf_read_o), 0);

    // Random traffic against a transaction-level model.
    begin
      bit            m_cmd = 0;
      bit            m_fld = 0;
      int            m_w = 0;
      bit            m_sg = 0;
      int            m_fw = 0;
      logic [DW-1:0] got;
      bit            e_ready;
      bit            e_read;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
        tick();
        rst_i         = ($urandom_range(0, 149) == 0);
        cmd_valid_i   = $urandom_range(0, 2) != 0;
        cmd_width_i   = CW'($urandom_range(0, 25));
        cmd_signed_i  = $urandom_range(0, 1) != 0;
        bf_rlevel_i   = LW'($urandom_range(0, 42));
        bf_rdata_i    = DW'($urandom);
        field_ready_i = $urandom_range(0, 3) != 0;
        @(negedge clk);
        e_ready = !m_cmd && (!m_fld || field_ready_i);
        e_read  = m_cmd && (int'(bf_rlevel_i) >= m_w) && !rst_i;
        chk("rnd_cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
        chk("rnd_read", 32'(bf_read_o), 32'(e_read));
        chk("rnd_rwidth", 32'(bf_rwidth_o), e_read ? 32'(m_w) : 0);
        chk("rnd_valid", 32'(field_valid_o), 32'(m_fld));
        if (m_fld && exp_q.size() > 0) begin
          chk("rnd_field", 32'(field_o), 32'(exp_q[0]));
          chk("rnd_fwidth", 32'(field_width_o), 32'(m_fw));
        end
        if (rst_i) begin
          m_cmd = 0; m_fld = 0; exp_q.delete();
        end else begin
          if (m_fld && field_ready_i) begin
            m_fld = 0;
            if (exp_q.size() > 0) got = exp_q.pop_front();
          end
          if (e_read) begin
            m_cmd = 0; m_fld = 1; m_fw = m_w;
            exp_q.push_back(ref_field(bf_rdata_i, m_w, m_sg));
          end
          if (cmd_valid_i && e_ready) begin
            m_w = clamp_w(int'(cmd_width_i)); m_sg = cmd_signed_i;
            if (m_w == 0) begin
              m_fld = 1; m_fw = 0; exp_q.push_back('0);
            end else m_cmd = 1;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
